// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for transmit and receive stages
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SIGNAL,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int PACKET_SIZE_DEF = 4;
    localparam int CYCLE_DIV_DEF   = 100;

    localparam logic BS_IDLE  = 1'b1;
    localparam logic BS_START = 1'b0;

endpackage

// File: rtl/uart_trans_fsm_if.sv
// rtl/uart_trans_fsm_if.sv - button/data inputs and serial-side outputs of the UART transmitter
interface uart_trans_fsm_if
    import uart_pkg::*;
#(
    parameter int PACKET_SIZE = PACKET_SIZE_DEF
);
    logic                   send;
    logic [PACKET_SIZE-1:0] data_in;
    logic                   transSig;
    logic                   bsOut;
    logic                   busy;
    logic                   done;

    modport master (
        output send, data_in,
        input  transSig, bsOut, busy, done
    );

    modport slave (
        input  send, data_in,
        output transSig, bsOut, busy, done
    );
endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period tick generator, one pulse every CYCLE_DIV clocks
module uart_bit_timer #(
    parameter int CYCLE_DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(CYCLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(CYCLE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = ~clear && (cnt_q == LAST);
        cnt_d = (clear || tick) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_trans_fsm.sv
// rtl/uart_trans_fsm.sv - UART transmitter: request pulse then start/data(MSB first)/stop frame
module uart_trans_fsm
    import uart_pkg::*;
#(
    parameter int PACKET_SIZE = PACKET_SIZE_DEF,
    parameter int CYCLE_DIV   = CYCLE_DIV_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_trans_fsm_if.slave bus
);
    localparam int IW = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;

    uart_state_e            state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [PACKET_SIZE-1:0] shift_q, shift_d;
    logic                   s1_q, s2_q, s3_q;
    logic                   trans_q, trans_d;
    logic                   bs_q, bs_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   rise;
    logic                   tick;

    // s3 only remembers the previous s2 so a held button yields a single rise
    assign rise = s2_q & ~s3_q;

    uart_bit_timer #(
        .CYCLE_DIV(CYCLE_DIV)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = SIGNAL;
                    shift_d = bus.data_in;
                end
            end
            SIGNAL: if (tick) state_d = START;
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = IW'(PACKET_SIZE - 1);
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == '0) state_d = STOP;
                    else             idx_d   = idx_q - IW'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave a flop glitch-free
        trans_d = (state_d == SIGNAL);
        busy_d  = (state_d != IDLE);
        case (state_d)
            START:   bs_d = BS_START;
            DATA:    bs_d = shift_d[idx_d];
            default: bs_d = BS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            trans_q <= 1'b0;
            bs_q    <= BS_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            s1_q    <= bus.send;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            trans_q <= trans_d;
            bs_q    <= bs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.transSig = trans_q;
    assign bus.bsOut    = bs_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
